// File: rtl/fifo_pkg.sv
// Shared constants and parameter-legality helpers for the single-clock FIFO.
package fifo_pkg;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

   function automatic bit af_ok(input int af, input int depth);
      return (af >= 1) && (af <= depth);
   endfunction

   function automatic bit ae_ok(input int ae, input int depth);
      return (ae >= 0) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is deliberately not reset; only pointers define valid contents.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with optional first-word-fall-through read,
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter bit FWFT     = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [DATA_W-1:0]           data_in,
   input  logic                        wrreq,
   input  logic                        rdreq,
   output logic [DATA_W-1:0]           data_out,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [level_w(DEPTH)-1:0]   level,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_w(DEPTH);

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
   end
   if (!af_ok(AF_LEVEL, DEPTH)) begin : g_bad_af
      $error("sync_fifo: AF_LEVEL must lie in 1..DEPTH");
   end
   if (!ae_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae
      $error("sync_fifo: AE_LEVEL must lie in 0..DEPTH-1");
   end

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] rd_word;
   logic              wr_acc;
   logic              rd_acc;

   // Acceptance is judged against the registered flags; flush drops both requests.
   assign wr_acc = wrreq && !full  && !flush;
   assign rd_acc = rdreq && !empty && !flush;

   assign full         = (level == LVL_W'(DEPTH));
   assign empty        = (level == '0);
   assign almost_full  = (level >= LVL_W'(AF_LEVEL));
   assign almost_empty = (level <= LVL_W'(AE_LEVEL));

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (wrreq && full)  overflow  <= 1'b1;
         if (rdreq && empty) underflow <= 1'b1;
      end
   end

   if (FWFT) begin : g_fwft
      // Head word is shown as soon as it exists; zero while empty.
      assign data_out = empty ? '0 : rd_word;
   end else begin : g_std
      // Registered read data, loaded only by an accepted read.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)         data_out <= '0;
         else if (flush)  data_out <= '0;
         else if (rd_acc) data_out <= rd_word;
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-read instance (DEPTH 16) and a FWFT instance
// (DEPTH 4) share one stimulus stream and are compared to a queue-based model.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic       wrreq = 1'b0;
   logic       rdreq = 1'b0;
   logic [7:0] data_in = 8'h00;

   logic [7:0] dout0, dout1;
   logic       full0, empty0, af0, ae0, ov0, un0;
   logic       full1, empty1, af1, ae1, ov1, un1;
   logic [4:0] lvl0;
   logic [2:0] lvl1;

   always #5 clk = ~clk;

   sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wrreq(wrreq), .rdreq(rdreq),
      .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .level(lvl0), .overflow(ov0), .underflow(un0));

   sync_fifo #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wrreq(wrreq), .rdreq(rdreq),
      .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .level(lvl1), .overflow(ov1), .underflow(un1));

   localparam int DEP [2] = '{16, 4};
   localparam int AFL [2] = '{14, 3};
   localparam int AEL [2] = '{2, 1};

   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;

   logic [7:0] mq [2][$];
   bit         m_ov [2];
   bit         m_un [2];
   logic [7:0] m_do0;
   logic [7:0] exp_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         m_ov[i] = 1'b0;
         m_un[i] = 1'b0;
      end
      m_do0 = 8'h00;
      exp_q.delete();
   endtask

   // Apply one edge's worth of FIFO rules to the model, using the current inputs.
   task automatic model_edge();
      int         n;
      logic [7:0] w;
      for (int i = 0; i < 2; i++) begin
         if (flush) begin
            mq[i].delete();
            m_ov[i] = 1'b0;
            m_un[i] = 1'b0;
            if (i == 0) m_do0 = 8'h00;
         end else begin
            n = mq[i].size();
            if (wrreq && n == DEP[i]) m_ov[i] = 1'b1;
            if (rdreq && n == 0)      m_un[i] = 1'b1;
            if (rdreq && n > 0) begin
               w = mq[i].pop_front();
               if (i == 0) begin
                  m_do0 = w;
                  exp_q.push_back(w);
               end
            end
            if (wrreq && n < DEP[i]) mq[i].push_back(data_in);
         end
      end
   endtask

   task automatic check_inst(input int i, input logic [31:0] lvl, input logic f, input logic e,
                             input logic af, input logic ae, input logic ov, input logic un,
                             input logic [7:0] d);
      int         n;
      logic [7:0] ed;
      n = mq[i].size();
      if (i == 0) ed = m_do0;
      else        ed = (n == 0) ? 8'h00 : mq[i][0];
      chk($sformatf("dut%0d.level", i), lvl, n);
      chk($sformatf("dut%0d.full", i), {31'b0, f}, {31'b0, n == DEP[i]});
      chk($sformatf("dut%0d.empty", i), {31'b0, e}, {31'b0, n == 0});
      chk($sformatf("dut%0d.almost_full", i), {31'b0, af}, {31'b0, n >= AFL[i]});
      chk($sformatf("dut%0d.almost_empty", i), {31'b0, ae}, {31'b0, n <= AEL[i]});
      chk($sformatf("dut%0d.overflow", i), {31'b0, ov}, {31'b0, m_ov[i]});
      chk($sformatf("dut%0d.underflow", i), {31'b0, un}, {31'b0, m_un[i]});
      chk($sformatf("dut%0d.data_out", i), {24'b0, d}, {24'b0, ed});
   endtask

   task automatic check_both();
      check_inst(0, {27'b0, lvl0}, full0, empty0, af0, ae0, ov0, un0, dout0);
      check_inst(1, {29'b0, lvl1}, full1, empty1, af1, ae1, ov1, un1, dout1);
   endtask

   // Monitor: after each edge, pop the scoreboard when a read was accepted and compare flags.
   always @(posedge clk) begin
      if (mon_en) begin
         #2;
         if (exp_q.size() > 0) chk("dut0.read_word", {24'b0, dout0}, {24'b0, exp_q.pop_front()});
         check_both();
      end
   end

   // Drive one cycle from a falling edge; model follows the rising edge.
   task automatic step(input bit wr, input bit rd, input bit fl, input logic [7:0] d);
      wrreq   = wr;
      rdreq   = rd;
      flush   = fl;
      data_in = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic mid_reset();
      wrreq = 1'b0;
      rdreq = 1'b0;
      flush = 1'b0;
      #1 rst = 1'b1;
      #1 model_clear();
      check_both();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] r;
      model_clear();
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 check_both();
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
      step(1'b1, 1'b0, 1'b0, 8'd99);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      step(1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom));

      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 8'h3C);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'hA5);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h5A);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      step(1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      step(1'b1, 1'b1, 1'b1, 8'hEE);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h11);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      for (int c = 0; c < 300; c++) begin
         r = 8'($urandom);
         if (c == 150) mid_reset();
         if (c < 100)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, r);
         else if (c < 200)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0, r);
         else
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, r);
      end

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("scoreboard_leftover", exp_q.size(), 0);
      mon_en = 1'b0;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
